// File: rtl/stage_2_decode_pkg.sv
// Shared RV32I decode types, opcode constants and the pure decode / immediate helpers
// used by the decode stage and its register file.
package stage_2_decode_pkg;

  typedef logic        Clock;
  typedef logic        Bool;
  typedef logic [31:0] Addr;
  typedef logic [31:0] Instr;
  typedef logic [31:0] Word;
  typedef logic [4:0]  RegIdx;
  typedef logic [6:0]  Opcode;

  localparam Opcode OP_LUI    = 7'b0110111;
  localparam Opcode OP_AUIPC  = 7'b0010111;
  localparam Opcode OP_JAL    = 7'b1101111;
  localparam Opcode OP_JALR   = 7'b1100111;
  localparam Opcode OP_BRANCH = 7'b1100011;
  localparam Opcode OP_LOAD   = 7'b0000011;
  localparam Opcode OP_STORE  = 7'b0100011;
  localparam Opcode OP_IMM    = 7'b0010011;
  localparam Opcode OP_REG    = 7'b0110011;
  localparam Opcode OP_FENCE  = 7'b0001111;
  localparam Opcode OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_PASS_B = 4'hA;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } Control;

  localparam int     CTRL_W   = $bits(Control);
  localparam Control CTRL_NOP = '0;

  typedef enum logic {ST_RUN, ST_SQUASH} DecState;

  function automatic Word immGen(Instr i);
    Word imm;
    imm = '0;
    case (i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{i[31]}}, i[31:20]};
      OP_STORE:                 imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {i[31:12], 12'b0};
      OP_JAL:                   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

  // alu_op is {funct7[5], funct3}; only SRAI among immediates uses the funct7 bit.
  function automatic Control decodeCtrl(Instr i);
    Control c;
    c        = CTRL_NOP;
    c.funct3 = i[14:12];
    case (i[6:0])
      OP_LUI:    begin c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.alu_op = ALU_PASS_B; end
      OP_AUIPC:  begin c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.alu_src_pc = 1'b1; end
      OP_JAL:    begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src_imm = 1'b1; c.alu_src_pc = 1'b1; end
      OP_JALR:   begin c.reg_write = 1'b1; c.jump = 1'b1; c.jalr = 1'b1; c.alu_src_imm = 1'b1; end
      OP_BRANCH: begin c.branch = 1'b1; c.alu_src_imm = 1'b1; c.alu_src_pc = 1'b1; end
      OP_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src_imm = 1'b1; end
      OP_STORE:  begin c.mem_write = 1'b1; c.alu_src_imm = 1'b1; end
      OP_IMM:    begin
        c.reg_write   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.alu_op      = {(i[14:12] == 3'b101) ? i[30] : 1'b0, i[14:12]};
      end
      OP_REG:    begin c.reg_write = 1'b1; c.alu_op = {i[30], i[14:12]}; end
      OP_FENCE, OP_SYSTEM: c.funct3 = 3'b000;
      default:   begin c = CTRL_NOP; c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

  function automatic Bool usesRs1(Instr i);
    return !(i[6:0] == OP_LUI || i[6:0] == OP_AUIPC || i[6:0] == OP_JAL);
  endfunction

  function automatic Bool usesRs2(Instr i);
    return (i[6:0] == OP_REG || i[6:0] == OP_STORE || i[6:0] == OP_BRANCH);
  endfunction

endpackage

// File: rtl/stage_2_decode_if.sv
// Bundle between the decode stage and its neighbours: fetch input, hazard/writeback
// sideband from later stages, and the registered bundle handed to execute.
interface stage_2_decode_if;
  import stage_2_decode_pkg::*;

  Instr   instruction;
  Addr    next_address;
  Bool    flush;
  Bool    ex_is_load;
  RegIdx  ex_rd;
  Bool    wb_enable;
  RegIdx  wb_rd;
  Word    wb_data;

  Bool    stall;
  Control control;
  Word    imm;
  Word    rs1_value;
  Word    rs2_value;
  RegIdx  rs1;
  RegIdx  rs2;
  RegIdx  rd;
  Addr    pc;
  Addr    next_address_out;
  Bool    valid;

  modport master (
    output instruction, next_address, flush, ex_is_load, ex_rd, wb_enable, wb_rd, wb_data,
    input  stall, control, imm, rs1_value, rs2_value, rs1, rs2, rd, pc, next_address_out, valid
  );

  modport slave (
    input  instruction, next_address, flush, ex_is_load, ex_rd, wb_enable, wb_rd, wb_data,
    output stall, control, imm, rs1_value, rs2_value, rs1, rs2, rd, pc, next_address_out, valid
  );

endinterface

// File: rtl/stage_2_decode_regfile.sv
// Architectural register file: two combinational read ports that see a same-cycle
// writeback, one synchronous write port, x0 hardwired to zero.
module stage_2_decode_regfile
  import stage_2_decode_pkg::*;
#(
  parameter int  REG_COUNT   = 32,
  parameter Word RESET_VALUE = '0
) (
  input  Clock  clk,
  input  Bool   rst,
  input  RegIdx rs1_i,
  input  RegIdx rs2_i,
  output Word   rs1_value_o,
  output Word   rs2_value_o,
  input  Bool   wr_en_i,
  input  RegIdx wr_idx_i,
  input  Word   wr_data_i
);

  Word regs_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < REG_COUNT; k++) regs_q[k] <= RESET_VALUE;
    end else if (wr_en_i && wr_idx_i != '0) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Bypass lets decode see the value writeback commits on this same edge.
  always_comb begin
    rs1_value_o = '0;
    if (rs1_i == '0)                           rs1_value_o = '0;
    else if (wr_en_i && wr_idx_i == rs1_i)     rs1_value_o = wr_data_i;
    else                                       rs1_value_o = regs_q[rs1_i];
  end

  always_comb begin
    rs2_value_o = '0;
    if (rs2_i == '0)                           rs2_value_o = '0;
    else if (wr_en_i && wr_idx_i == rs2_i)     rs2_value_o = wr_data_i;
    else                                       rs2_value_o = regs_q[rs2_i];
  end

endmodule

// File: rtl/stage_2_decode.sv
// RV32I decode stage: decodes the fetched instruction, reads operands, stalls fetch on
// load-use hazards and squashes the two wrong-path slots that follow a taken jump.
module stage_2_decode
  import stage_2_decode_pkg::*;
#(
  parameter int  REG_COUNT   = 32,
  parameter Word RESET_VALUE = '0
) (
  input Clock             clk,
  input Bool              rst,
  stage_2_decode_if.slave bus_io
);

  Instr    instr;
  RegIdx   rs1Idx, rs2Idx;
  Word     rs1Value, rs2Value;
  Bool     hazard, emit;
  DecState state_q;

  Control  ctrl_d, ctrl_q;
  Word     imm_d, imm_q, rs1Value_d, rs1Value_q, rs2Value_d, rs2Value_q;
  RegIdx   rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  Addr     pc_d, pc_q, nextAddr_d, nextAddr_q;

  assign instr  = bus_io.instruction;
  assign rs1Idx = instr[19:15];
  assign rs2Idx = instr[24:20];

  stage_2_decode_regfile #(
    .REG_COUNT  (REG_COUNT),
    .RESET_VALUE(RESET_VALUE)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs1_i      (rs1Idx),
    .rs2_i      (rs2Idx),
    .rs1_value_o(rs1Value),
    .rs2_value_o(rs2Value),
    .wr_en_i    (bus_io.wb_enable),
    .wr_idx_i   (bus_io.wb_rd),
    .wr_data_i  (bus_io.wb_data)
  );

  assign hazard = bus_io.ex_is_load && (bus_io.ex_rd != '0) &&
                  ((usesRs1(instr) && rs1Idx == bus_io.ex_rd) ||
                   (usesRs2(instr) && rs2Idx == bus_io.ex_rd));

  // A flush or a pending squash already discards this slot, so holding fetch would be wrong.
  assign bus_io.stall = hazard && !bus_io.flush && (state_q != ST_SQUASH);
  assign emit         = !bus_io.flush && (state_q != ST_SQUASH) && !hazard;

  always_comb begin
    ctrl_d     = CTRL_NOP;
    imm_d      = '0;
    rs1Value_d = '0;
    rs2Value_d = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    pc_d       = '0;
    nextAddr_d = '0;
    if (emit) begin
      ctrl_d     = decodeCtrl(instr);
      imm_d      = immGen(instr);
      rs1Value_d = rs1Value;
      rs2Value_d = rs2Value;
      rs1_d      = rs1Idx;
      rs2_d      = rs2Idx;
      rd_d       = instr[11:7];
      pc_d       = bus_io.next_address - 32'd4;
      nextAddr_d = bus_io.next_address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ctrl_q     <= CTRL_NOP;
      imm_q      <= '0;
      rs1Value_q <= '0;
      rs2Value_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      nextAddr_q <= '0;
    end else begin
      state_q    <= bus_io.flush ? ST_SQUASH : ST_RUN;
      ctrl_q     <= ctrl_d;
      imm_q      <= imm_d;
      rs1Value_q <= rs1Value_d;
      rs2Value_q <= rs2Value_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      nextAddr_q <= nextAddr_d;
    end
  end

  logic valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= emit;
  end

  assign bus_io.control          = ctrl_q;
  assign bus_io.imm              = imm_q;
  assign bus_io.rs1_value        = rs1Value_q;
  assign bus_io.rs2_value        = rs2Value_q;
  assign bus_io.rs1              = rs1_q;
  assign bus_io.rs2              = rs2_q;
  assign bus_io.rd               = rd_q;
  assign bus_io.pc               = pc_q;
  assign bus_io.next_address_out = nextAddr_q;
  assign bus_io.valid            = valid_q;

endmodule

// File: tb/tb_stage_2_decode.sv
// Scoreboard bench for stage_2_decode: instructions are built from chosen fields and
// immediates, expected bundles queued at issue and compared by an independent monitor.
module tb_stage_2_decode;
  import stage_2_decode_pkg::*;

  localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4;
  localparam int C_LD  = 5, C_ST    = 6, C_OPI = 7, C_OP   = 8, C_ILL = 9;

  typedef struct { logic [31:0] instr; int cls; logic [31:0] imm; } Ins;
  typedef struct {
    logic valid; Control ctrl; logic [31:0] imm, v1, v2; logic [4:0] rs1, rs2, rd; logic [31:0] pc, na;
  } Exp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_2_decode_if bus();

  stage_2_decode #(.REG_COUNT(32), .RESET_VALUE(32'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  Exp          expQ[$];
  logic [31:0] mRegs [32];
  logic        mSquash   = 1'b0;
  logic        lastStall = 1'b0;
  int          checks    = 0;
  int          failures  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Encoders: the expected immediate is the value chosen, not one re-extracted from bits.
  function automatic Ins mkI(int cls, logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, int v);
    Ins r; logic [31:0] w;
    w = 32'(v);
    r.cls = cls; r.imm = w; r.instr = {w[11:0], rs1, f3, rd, op};
    return r;
  endfunction

  function automatic Ins mkS(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, int v);
    Ins r; logic [31:0] w;
    w = 32'(v);
    r.cls = C_ST; r.imm = w; r.instr = {w[11:5], rs2, rs1, f3, w[4:0], 7'b0100011};
    return r;
  endfunction

  function automatic Ins mkB(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, int v);
    Ins r; logic [31:0] w;
    w = 32'(v);
    r.cls = C_BR; r.imm = w; r.instr = {w[12], w[10:5], rs2, rs1, f3, w[4:1], w[11], 7'b1100011};
    return r;
  endfunction

  function automatic Ins mkU(int cls, logic [6:0] op, logic [4:0] rd, logic [31:0] v);
    Ins r;
    r.cls = cls; r.imm = {v[31:12], 12'b0}; r.instr = {v[31:12], rd, op};
    return r;
  endfunction

  function automatic Ins mkJ(logic [4:0] rd, int v);
    Ins r; logic [31:0] w;
    w = 32'(v);
    r.cls = C_JAL; r.imm = w; r.instr = {w[20], w[10:1], w[11], w[19:12], rd, 7'b1101111};
    return r;
  endfunction

  function automatic Ins mkR(logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic alt);
    Ins r;
    r.cls = C_OP; r.imm = '0; r.instr = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
    return r;
  endfunction

  function automatic Ins mkIll(logic [31:0] junk);
    Ins r;
    r.cls = C_ILL; r.imm = '0; r.instr = {junk[24:0], 7'b1111111};
    return r;
  endfunction

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic int simm12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic Ins randIns();
    int         cls;
    logic [2:0] f3;
    cls = int'($urandom_range(0, 9));
    f3  = 3'($urandom_range(0, 7));
    case (cls)
      C_LUI:   return mkU(C_LUI, 7'b0110111, rreg(), $urandom);
      C_AUIPC: return mkU(C_AUIPC, 7'b0010111, rreg(), $urandom);
      C_JAL:   return mkJ(rreg(), (int'($urandom_range(0, 1048575)) - 524288) * 2);
      C_JALR:  return mkI(C_JALR, 7'b1100111, 3'b000, rreg(), rreg(), simm12());
      C_BR:    return mkB(f3, rreg(), rreg(), (int'($urandom_range(0, 4095)) - 2048) * 2);
      C_LD:    return mkI(C_LD, 7'b0000011, f3, rreg(), rreg(), simm12());
      C_ST:    return mkS(f3, rreg(), rreg(), simm12());
      C_OPI:   return mkI(C_OPI, 7'b0010011, f3, rreg(), rreg(), simm12());
      C_OP:    return mkR(f3, rreg(), rreg(), rreg(), 1'($urandom_range(0, 1)));
      default: return mkIll($urandom);
    endcase
  endfunction

  // Control bundle each instruction class must produce.
  function automatic Control expCtrl(Ins s);
    Control c; logic [2:0] f3;
    f3 = s.instr[14:12];
    c = '0;
    c.funct3 = f3;
    case (s.cls)
      C_LUI:   begin c.reg_write = 1; c.alu_src_imm = 1; c.alu_op = 4'hA; end
      C_AUIPC: begin c.reg_write = 1; c.alu_src_imm = 1; c.alu_src_pc = 1; end
      C_JAL:   begin c.reg_write = 1; c.jump = 1; c.alu_src_imm = 1; c.alu_src_pc = 1; end
      C_JALR:  begin c.reg_write = 1; c.jump = 1; c.jalr = 1; c.alu_src_imm = 1; end
      C_BR:    begin c.branch = 1; c.alu_src_imm = 1; c.alu_src_pc = 1; end
      C_LD:    begin c.reg_write = 1; c.mem_read = 1; c.alu_src_imm = 1; end
      C_ST:    begin c.mem_write = 1; c.alu_src_imm = 1; end
      C_OPI:   begin c.reg_write = 1; c.alu_src_imm = 1; c.alu_op = {(f3 == 3'd5) ? s.instr[30] : 1'b0, f3}; end
      C_OP:    begin c.reg_write = 1; c.alu_op = {s.instr[30], f3}; end
      default: begin c = '0; c.illegal = 1; end
    endcase
    return c;
  endfunction

  function automatic logic [31:0] readModel(logic [4:0] idx, logic wbe, logic [4:0] wbrd, logic [31:0] wbd);
    if (idx == 0)                return 32'h0;
    if (wbe && wbrd == idx)      return wbd;
    return mRegs[idx];
  endfunction

  task automatic applyStimulus(input Ins s, input logic [31:0] na, input logic fl, input logic exl,
                               input logic [4:0] exrd, input logic wbe, input logic [4:0] wbrd,
                               input logic [31:0] wbd);
    Exp e; logic u1, u2, hz, expStall; logic [4:0] r1, r2;
    @(posedge clk); #2;
    bus.instruction = s.instr; bus.next_address = na; bus.flush = fl;
    bus.ex_is_load = exl; bus.ex_rd = exrd; bus.wb_enable = wbe; bus.wb_rd = wbrd; bus.wb_data = wbd;
    #1;
    r1 = s.instr[19:15];
    r2 = s.instr[24:20];
    u1 = !(s.cls == C_LUI || s.cls == C_AUIPC || s.cls == C_JAL);
    u2 = (s.cls == C_OP || s.cls == C_ST || s.cls == C_BR);
    hz = exl && exrd != 0 && ((u1 && r1 == exrd) || (u2 && r2 == exrd));
    expStall = hz && !fl && !mSquash;
    checkOutput("stall_out", 32'(bus.stall), 32'(expStall));
    e.valid = 0; e.ctrl = '0; e.imm = 0; e.v1 = 0; e.v2 = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.pc = 0; e.na = 0;
    if (fl)           mSquash = 1'b1;
    else if (mSquash) mSquash = 1'b0;
    else if (!hz) begin
      e.valid = 1; e.ctrl = expCtrl(s); e.imm = s.imm;
      e.v1 = readModel(r1, wbe, wbrd, wbd); e.v2 = readModel(r2, wbe, wbrd, wbd);
      e.rs1 = r1; e.rs2 = r2; e.rd = s.instr[11:7]; e.pc = na - 32'd4; e.na = na;
    end
    expQ.push_back(e);
    if (wbe && wbrd != 0) mRegs[wbrd] = wbd;
    lastStall = expStall;
  endtask

  task automatic driveIdle();
    bus.instruction = 32'h0000_0013; bus.next_address = 0; bus.flush = 0; bus.ex_is_load = 0;
    bus.ex_rd = 0; bus.wb_enable = 0; bus.wb_rd = 0; bus.wb_data = 0;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst = 1'b1;
    driveIdle();
    #1;
    checkOutput("reset_valid", 32'(bus.valid), 0);
    checkOutput("reset_control", 32'(bus.control), 0);
    checkOutput("reset_imm", bus.imm, 0);
    checkOutput("reset_rs1_value", bus.rs1_value, 0);
    checkOutput("reset_rd", 32'(bus.rd), 0);
    checkOutput("reset_pc", bus.pc, 0);
    checkOutput("reset_next_address", bus.next_address_out, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) mRegs[k] = 32'h0;
    mSquash = 1'b0; lastStall = 1'b0;
    expQ.delete();
  endtask

  // Monitor: every edge the DUT presents a bundle; compare against the oldest expectation.
  initial begin
    Exp e;
    forever begin
      @(posedge clk); #1;
      if (!rst && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("valid_out", 32'(bus.valid), 32'(e.valid));
        checkOutput("control_out", 32'(bus.control), 32'(e.ctrl));
        if (e.valid) begin
          checkOutput("imm_out", bus.imm, e.imm);
          checkOutput("rs1_value_out", bus.rs1_value, e.v1);
          checkOutput("rs2_value_out", bus.rs2_value, e.v2);
          checkOutput("rs1_out", 32'(bus.rs1), 32'(e.rs1));
          checkOutput("rs2_out", 32'(bus.rs2), 32'(e.rs2));
          checkOutput("rd_out", 32'(bus.rd), 32'(e.rd));
          checkOutput("pc_out", bus.pc, e.pc);
          checkOutput("next_address_out", bus.next_address_out, e.na);
        end
      end
    end
  end

  initial begin
    Ins          cur, add432;
    logic [31:0] curNa;
    driveIdle();
    for (int k = 0; k < 32; k++) mRegs[k] = 32'h0;
    doReset();

    applyStimulus(mkI(C_OPI, 7'b0010011, 3'b000, 5'd1, 5'd0, -5), 32'h104, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkI(C_OPI, 7'b0010011, 3'b000, 5'd2, 5'd1, 17), 32'h0, 0, 0, 0, 0, 0, 0);

    add432 = mkR(3'b000, 5'd4, 5'd3, 5'd2, 1'b0);
    applyStimulus(add432, 32'h200, 0, 1, 5'd3, 0, 0, 0);
    applyStimulus(add432, 32'h200, 0, 0, 5'd3, 0, 0, 0);
    applyStimulus(add432, 32'h204, 0, 1, 5'd0, 0, 0, 0);

    applyStimulus(mkR(3'b000, 5'd1, 5'd2, 5'd3, 1'b1), 32'h300, 1, 0, 0, 0, 0, 0);
    applyStimulus(mkR(3'b111, 5'd1, 5'd2, 5'd3, 1'b0), 32'h304, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkR(3'b110, 5'd5, 5'd6, 5'd7, 1'b0), 32'h400, 0, 0, 0, 0, 0, 0);
    applyStimulus(add432, 32'h500, 1, 1, 5'd3, 0, 0, 0);
    applyStimulus(add432, 32'h504, 0, 1, 5'd3, 0, 0, 0);
    applyStimulus(add432, 32'h600, 0, 0, 5'd3, 0, 0, 0);

    applyStimulus(mkR(3'b000, 5'd8, 5'd7, 5'd7, 1'b0), 32'h700, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
    applyStimulus(mkR(3'b000, 5'd9, 5'd7, 5'd0, 1'b0), 32'h704, 0, 0, 0, 1, 5'd0, 32'h12345678);
    applyStimulus(mkR(3'b000, 5'd10, 5'd0, 5'd0, 1'b0), 32'h708, 0, 0, 0, 0, 0, 0);

    applyStimulus(mkB(3'b000, 5'd1, 5'd2, -8), 32'h800, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkS(3'b010, 5'd2, 5'd7, -4), 32'h804, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkJ(5'd1, -2048), 32'h808, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkU(C_LUI, 7'b0110111, 5'd3, 32'hABCDE000), 32'h80C, 0, 0, 0, 0, 0, 0);
    applyStimulus(mkIll(32'h0123_4567), 32'h810, 0, 0, 0, 0, 0, 0);

    applyStimulus(mkR(3'b000, 5'd6, 5'd5, 5'd5, 1'b0), 32'h900, 0, 0, 0, 1, 5'd5, 32'hCAFE_F00D);
    applyStimulus(mkR(3'b000, 5'd6, 5'd5, 5'd5, 1'b0), 32'h904, 0, 0, 0, 0, 0, 0);
    doReset();
    applyStimulus(mkR(3'b000, 5'd6, 5'd5, 5'd5, 1'b0), 32'h908, 0, 0, 0, 0, 0, 0);

    cur = randIns(); curNa = $urandom;
    for (int n = 0; n < 400; n++) begin
      if (!lastStall) begin
        cur   = randIns();
        curNa = $urandom;
      end
      applyStimulus(cur, curNa, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) @(posedge clk);
    #3;
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
